// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared divider sequencing definitions
package cpu_defs;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_SEND = 2'd1,
    DIV_WAIT = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  // Core output word: quotient in the upper half, remainder in the lower half
  localparam int QUO_HI = 2*DIV_W-1;
  localparam int QUO_LO = DIV_W;
  localparam int REM_HI = DIV_W-1;
  localparam int REM_LO = 0;

endpackage

// File: rtl/div_axis_src.sv
// rtl/div_axis_src.sv - single AXI-stream source channel: tvalid plus accepted flag
module div_axis_src (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic clear,
  input  logic tready,
  output logic tvalid,
  output logic accepted
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tvalid   <= 1'b0;
      accepted <= 1'b0;
    end else if (start) begin
      tvalid   <= 1'b1;
      accepted <= 1'b0;
    end else if (clear) begin
      tvalid   <= 1'b0;
      accepted <= 1'b0;
    end else if (tvalid && tready) begin
      tvalid   <= 1'b0;
      accepted <= 1'b1;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sequences the signed/unsigned divider cores for the EXE stage
module div_ctrl
  import cpu_defs::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req,
  input  logic               div_signed,
  input  logic               op_mod,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  input  logic               cancel,
  input  logic               res_ready,
  output logic               s_dividend_tvalid,
  output logic               u_dividend_tvalid,
  input  logic               s_dividend_tready,
  input  logic               u_dividend_tready,
  output logic               s_divisor_tvalid,
  output logic               u_divisor_tvalid,
  input  logic               s_divisor_tready,
  input  logic               u_divisor_tready,
  output logic [WIDTH-1:0]   dividend_tdata,
  output logic [WIDTH-1:0]   divisor_tdata,
  input  logic               s_dout_tvalid,
  input  logic               u_dout_tvalid,
  input  logic [2*WIDTH-1:0] s_dout_tdata,
  input  logic [2*WIDTH-1:0] u_dout_tdata,
  output logic [WIDTH-1:0]   result,
  output logic               complete,
  output logic               busy
);

  div_state_t         state;
  logic               sgn;
  logic               mod;
  logic               drop;
  logic               launch;
  logic               in_idle;
  logic               dvd_tvalid, dvd_acc, dvd_tready;
  logic               dvs_tvalid, dvs_acc, dvs_tready;
  logic               both_acc;
  logic               dout_tvalid;
  logic [2*WIDTH-1:0] dout_tdata;

  assign in_idle = (state == DIV_IDLE);
  assign launch  = in_idle && req && !cancel;
  assign busy    = !in_idle;

  assign dvd_tready  = sgn ? s_dividend_tready : u_dividend_tready;
  assign dvs_tready  = sgn ? s_divisor_tready  : u_divisor_tready;
  assign dout_tvalid = sgn ? s_dout_tvalid     : u_dout_tvalid;
  assign dout_tdata  = sgn ? s_dout_tdata      : u_dout_tdata;

  assign s_dividend_tvalid = dvd_tvalid &  sgn;
  assign u_dividend_tvalid = dvd_tvalid & ~sgn;
  assign s_divisor_tvalid  = dvs_tvalid &  sgn;
  assign u_divisor_tvalid  = dvs_tvalid & ~sgn;

  // A channel counts as accepted on its handshake cycle, not only once the flag is set
  assign both_acc = (dvd_acc || (dvd_tvalid && dvd_tready)) &&
                    (dvs_acc || (dvs_tvalid && dvs_tready));

  div_axis_src u_dividend (
    .clk      (clk),
    .resetn   (resetn),
    .start    (launch),
    .clear    (in_idle),
    .tready   (dvd_tready),
    .tvalid   (dvd_tvalid),
    .accepted (dvd_acc)
  );

  div_axis_src u_divisor (
    .clk      (clk),
    .resetn   (resetn),
    .start    (launch),
    .clear    (in_idle),
    .tready   (dvs_tready),
    .tvalid   (dvs_tvalid),
    .accepted (dvs_acc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= DIV_IDLE;
      sgn            <= 1'b0;
      mod            <= 1'b0;
      drop           <= 1'b0;
      dividend_tdata <= '0;
      divisor_tdata  <= '0;
      result         <= '0;
      complete       <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (launch) begin
            dividend_tdata <= src1;
            divisor_tdata  <= src2;
            sgn            <= div_signed;
            mod            <= op_mod;
            drop           <= 1'b0;
            state          <= DIV_SEND;
          end
        end
        DIV_SEND: begin
          if (cancel) drop <= 1'b1;
          if (both_acc) state <= DIV_WAIT;
        end
        DIV_WAIT: begin
          if (cancel) drop <= 1'b1;
          // A flushed divide still drains the core so its output is not left pending
          if (dout_tvalid) begin
            if (drop || cancel) begin
              state <= DIV_IDLE;
            end else begin
              result   <= mod ? dout_tdata[REM_HI:REM_LO] : dout_tdata[QUO_HI:QUO_LO];
              complete <= 1'b1;
              state    <= DIV_DONE;
            end
          end
        end
        DIV_DONE: begin
          if (cancel || res_ready) begin
            complete <= 1'b0;
            state    <= DIV_IDLE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule
